// File: rtl/mic_frame_scheduler.sv
// Walks NUM_MICS PCM FIFOs once per SPI chip-select frame. Each sample is prefetched into a
// staging word ahead of spi_slave's dataNeeded. Build macro FRAME_HDR_EN adds a header word per frame.
module mic_frame_scheduler #(
  parameter int NUM_MICS  = 9,
  parameter int BIT_WIDTH = 19
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          ssel,
  input  logic                          data_needed,
  input  logic [NUM_MICS-1:0]           fifo_rdempty,
  input  logic [NUM_MICS*BIT_WIDTH-1:0] fifo_q,
  output logic [NUM_MICS-1:0]           fifo_rdreq,
  output logic [23:0]                   spi_data_to_send,
  output logic                          frame_active,
  output logic                          frame_done,
  output logic                          frame_abort,
  output logic [2:0]                    dbg_state
);

  localparam int MIC_W = (NUM_MICS > 1) ? $clog2(NUM_MICS) : 1;
  localparam logic [MIC_W-1:0] LAST_MIC = MIC_W'(NUM_MICS - 1);
  localparam logic [23:0] UNDERRUN_WORD = 24'h800000;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HDR    = 3'd1,
    S_FETCH  = 3'd2,
    S_LATCH  = 3'd3,
    S_WAIT   = 3'd4,
    S_FINISH = 3'd5
  } state_t;

`ifdef FRAME_HDR_EN
  localparam state_t S_FIRST = S_HDR;
`else
  localparam state_t S_FIRST = S_FETCH;
`endif

  // Handshake: a frame is framed by ssel low; each synchronised rising edge of data_needed
  // consumes exactly one word, and the word is on spi_data_to_send from the following cycle.

  // [0],[1] are the synchroniser stages, [2] is the previous synchronised value for edge detect.
  logic [2:0] ssel_sync;
  logic [2:0] dn_sync;
  logic       ssel_fall, ssel_rise, dn_rise;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ssel_sync <= 3'b111;
      dn_sync   <= 3'b000;
    end else begin
      ssel_sync <= {ssel_sync[1:0], ssel};
      dn_sync   <= {dn_sync[1:0], data_needed};
    end
  end

  assign ssel_fall = ssel_sync[2] & ~ssel_sync[1];
  assign ssel_rise = ~ssel_sync[2] & ssel_sync[1];
  assign dn_rise   = ~dn_sync[2] & dn_sync[1];

  logic [BIT_WIDTH-1:0] q_arr [NUM_MICS];
  for (genvar g = 0; g < NUM_MICS; g++) begin : g_q
    assign q_arr[g] = fifo_q[g*BIT_WIDTH +: BIT_WIDTH];
  end

  state_t           state, state_n;
  logic [MIC_W-1:0] mic, mic_n;
  logic             pend, pend_n;
  logic             was_empty, was_empty_n;
  logic [23:0]      staging, staging_n;
  logic [23:0]      spi_n;

`ifdef FRAME_HDR_EN
  logic [7:0] frame_cnt, frame_cnt_n;
  logic [7:0] urun_cur, urun_cur_n;
  logic [7:0] urun_prev, urun_prev_n;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= S_IDLE;
      mic              <= '0;
      pend             <= 1'b0;
      was_empty        <= 1'b0;
      staging          <= '0;
      spi_data_to_send <= '0;
`ifdef FRAME_HDR_EN
      frame_cnt        <= '0;
      urun_cur         <= '0;
      urun_prev        <= '0;
`endif
    end else begin
      state            <= state_n;
      mic              <= mic_n;
      pend             <= pend_n;
      was_empty        <= was_empty_n;
      staging          <= staging_n;
      spi_data_to_send <= spi_n;
`ifdef FRAME_HDR_EN
      frame_cnt        <= frame_cnt_n;
      urun_cur         <= urun_cur_n;
      urun_prev        <= urun_prev_n;
`endif
    end
  end

  always_comb begin
    state_n     = state;
    mic_n       = mic;
    pend_n      = pend;
    was_empty_n = was_empty;
    staging_n   = staging;
    spi_n       = spi_data_to_send;
    fifo_rdreq  = '0;
    frame_abort = 1'b0;
`ifdef FRAME_HDR_EN
    frame_cnt_n = frame_cnt;
    urun_cur_n  = urun_cur;
    urun_prev_n = urun_prev;
    if (state == S_FINISH) begin
      frame_cnt_n = frame_cnt + 8'd1;
      urun_prev_n = urun_cur;
    end
`endif

    // Requests outside a frame are answered with an all-zero word.
    if (dn_rise && (state == S_IDLE || state == S_FINISH))
      spi_n = '0;

    if (ssel_rise && state != S_IDLE) begin
      state_n     = S_IDLE;
      mic_n       = '0;
      pend_n      = 1'b0;
      frame_abort = (state != S_FINISH);
    end else if (ssel_fall) begin
      state_n = S_FIRST;
      mic_n   = '0;
      pend_n  = 1'b0;
`ifdef FRAME_HDR_EN
      urun_cur_n = '0;
`endif
    end else begin
      case (state)
`ifdef FRAME_HDR_EN
        S_HDR: begin
          if (dn_rise) begin
            spi_n   = {8'hA5, frame_cnt, urun_prev};
            state_n = S_FETCH;
          end
        end
`endif
        S_FETCH: begin
          was_empty_n = fifo_rdempty[mic];
          fifo_rdreq[mic] = ~fifo_rdempty[mic];
          if (dn_rise) pend_n = 1'b1;
          state_n = S_LATCH;
        end
        S_LATCH: begin
          // Non-show-ahead FIFO: q carries the sample one cycle after rdreq.
          staging_n = was_empty ? UNDERRUN_WORD : {1'b0, 23'(q_arr[mic])};
`ifdef FRAME_HDR_EN
          if (was_empty) urun_cur_n = urun_cur + 8'd1;
`endif
          if (dn_rise) pend_n = 1'b1;
          state_n = S_WAIT;
        end
        S_WAIT: begin
          if (dn_rise || pend) begin
            spi_n  = staging;
            pend_n = 1'b0;
            if (mic == LAST_MIC) begin
              state_n = S_FINISH;
            end else begin
              mic_n   = mic + MIC_W'(1);
              state_n = S_FETCH;
            end
          end
        end
        S_FINISH: state_n = S_IDLE;
        default:  state_n = S_IDLE;
      endcase
    end
  end

  assign frame_active = (state == S_HDR) || (state == S_FETCH) ||
                        (state == S_LATCH) || (state == S_WAIT);
  assign frame_done   = (state == S_FINISH);
  assign dbg_state    = state;

endmodule

// File: tb/tb_mic_frame_scheduler.sv
// Randomised bench for mic_frame_scheduler: FIFO models feed the DUT, and a queue-based
// reference predicts each frame's words from the FIFO contents when the frame starts.
module tb_mic_frame_scheduler;

  localparam int NUM_MICS  = 9;
  localparam int BIT_WIDTH = 19;
  localparam int DEPTH     = 8;
`ifdef FRAME_HDR_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam int LEN = NUM_MICS + HDR;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic                          ssel = 1'b1;
  logic                          data_needed = 1'b0;
  logic [NUM_MICS-1:0]           fifo_rdempty;
  logic [NUM_MICS*BIT_WIDTH-1:0] fifo_q = '0;
  logic [NUM_MICS-1:0]           fifo_rdreq;
  logic [23:0]                   spi_data_to_send;
  logic                          frame_active, frame_done, frame_abort;
  logic [2:0]                    dbg_state;

  mic_frame_scheduler #(.NUM_MICS(NUM_MICS), .BIT_WIDTH(BIT_WIDTH)) dut (
    .clk(clk), .reset_n(reset_n), .ssel(ssel), .data_needed(data_needed),
    .fifo_rdempty(fifo_rdempty), .fifo_q(fifo_q), .fifo_rdreq(fifo_rdreq),
    .spi_data_to_send(spi_data_to_send), .frame_active(frame_active),
    .frame_done(frame_done), .frame_abort(frame_abort), .dbg_state(dbg_state)
  );

  // ---------------- FIFO models (non-show-ahead) ----------------
  logic [BIT_WIDTH-1:0] fifo_mem [NUM_MICS][DEPTH];
  int wr_cnt [NUM_MICS] = '{default: 0};
  int rd_cnt [NUM_MICS] = '{default: 0};

  for (genvar g = 0; g < NUM_MICS; g++) begin : g_empty
    assign fifo_rdempty[g] = (wr_cnt[g] == rd_cnt[g]);
  end

  always @(posedge clk) begin
    for (int m = 0; m < NUM_MICS; m++)
      if (fifo_rdreq[m] && wr_cnt[m] != rd_cnt[m]) begin
        fifo_q[m*BIT_WIDTH +: BIT_WIDTH] <= fifo_mem[m][rd_cnt[m] % DEPTH];
        rd_cnt[m] <= rd_cnt[m] + 1;
      end
  end

  // ---------------- output monitor ----------------
  int rdreq_total = 0, multi_hot = 0, rd_on_empty = 0, done_cnt = 0, abort_cnt = 0;
  always @(negedge clk) begin
    if ($countones(fifo_rdreq) > 1) multi_hot++;
    for (int m = 0; m < NUM_MICS; m++)
      if (fifo_rdreq[m] && fifo_rdempty[m]) rd_on_empty++;
    rdreq_total += $countones(fifo_rdreq);
    if (frame_done)  done_cnt++;
    if (frame_abort) abort_cnt++;
  end

  // ---------------- reference model / scoreboard ----------------
  logic [BIT_WIDTH-1:0] ref_q [NUM_MICS][$];
  logic [23:0]          exp_q [$];
  logic [7:0]           m_frame_cnt = 8'd0;
  logic [7:0]           m_urun_prev = 8'd0;
  int n_cmp = 0, n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push(input int m, input logic [BIT_WIDTH-1:0] val);
    fifo_mem[m][wr_cnt[m] % DEPTH] = val;
    wr_cnt[m] = wr_cnt[m] + 1;
    ref_q[m].push_back(val);
  endtask

  task automatic dn_pulse();
    data_needed = 1'b1;
    repeat (4) @(negedge clk);
    data_needed = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  // served >= LEN runs a complete frame; otherwise ssel rises after 'served' words.
  task automatic run_frame(input int served, input bit early, input bit extra);
    int consumed, exp_rd, urun, rd0, done0, ab0;
    bit full;
    full = (served >= LEN);
    if (full) served = LEN;
    // Mic k's sample is read as soon as the previous word is handed over.
    consumed = full ? NUM_MICS : ((HDR != 0) ? served : served + 1);
    if (consumed > NUM_MICS) consumed = NUM_MICS;
    exp_q.delete();
    if (HDR != 0) exp_q.push_back({8'hA5, m_frame_cnt, m_urun_prev});
    exp_rd = 0;
    urun = 0;
    for (int k = 0; k < consumed; k++) begin
      if (ref_q[k].size() > 0) begin
        exp_q.push_back(24'(ref_q[k].pop_front()));
        exp_rd++;
      end else begin
        exp_q.push_back(24'h800000);
        urun++;
      end
    end
    if (full) begin
      m_frame_cnt = m_frame_cnt + 8'd1;
      m_urun_prev = 8'(urun);
    end

    rd0 = rdreq_total; done0 = done_cnt; ab0 = abort_cnt;
    ssel = 1'b0;
    if (early) @(negedge clk);
    else repeat (6) @(negedge clk);
    for (int w = 0; w < served; w++) begin
      dn_pulse();
      check("word", spi_data_to_send, exp_q.pop_front());
      if (w == 0 && served > 1) check("active_mid", frame_active, 1);
    end
    if (full) begin
      check("active_end", frame_active, 0);
      check("done_once", done_cnt - done0, 1);
      check("no_abort", abort_cnt - ab0, 0);
      if (extra) begin
        dn_pulse();
        check("idle_word", spi_data_to_send, 0);
      end
      check("rdreq_cnt", rdreq_total - rd0, exp_rd);
      ssel = 1'b1;
      repeat (6) @(negedge clk);
      check("idle_rise_no_abort", abort_cnt - ab0, 0);
    end else begin
      ssel = 1'b1;
      repeat (6) @(negedge clk);
      check("abort_once", abort_cnt - ab0, 1);
      check("abort_no_done", done_cnt - done0, 0);
      check("abort_inactive", frame_active, 0);
      check("abort_idle", dbg_state, 0);
      check("abort_rdreq_cnt", rdreq_total - rd0, exp_rd);
    end
  endtask

  task automatic fill_all(input int skip_mic);
    for (int m = 0; m < NUM_MICS; m++)
      if (m != skip_mic) push(m, BIT_WIDTH'($urandom));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    #1;
    check("rst_word", spi_data_to_send, 0);
    check("rst_rdreq", fifo_rdreq, 0);
    check("rst_active", frame_active, 0);
    check("rst_done", frame_done, 0);
    check("rst_abort", frame_abort, 0);
    check("rst_state", dbg_state, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // mic i holds i+1; plus a stray request after the frame
    for (int m = 0; m < NUM_MICS; m++) push(m, BIT_WIDTH'(m + 1));
    run_frame(LEN, 1'b0, 1'b1);

    // mic 3 empty -> underrun word in its slot
    fill_all(3);
    run_frame(LEN, 1'b0, 1'b0);

    // abort after 4 words, then a clean frame from mic 0
    fill_all(-1);
    fill_all(-1);
    run_frame(4, 1'b0, 1'b0);
    run_frame(LEN, 1'b0, 1'b0);

    // request arriving one cycle after chip select
    fill_all(-1);
    run_frame(LEN, 1'b1, 1'b0);

    // randomised frames
    for (int f = 0; f < 10; f++) begin
      for (int m = 0; m < NUM_MICS; m++)
        if (ref_q[m].size() < 3) begin
          int n;
          n = $urandom_range(0, 2);
          for (int i = 0; i < n; i++) push(m, BIT_WIDTH'($urandom));
        end
      if ($urandom_range(0, 3) == 0)
        run_frame($urandom_range(1, LEN - 1), 1'($urandom_range(0, 1)), 1'b0);
      else
        run_frame(LEN, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // asynchronous reset in the middle of a frame
    fill_all(-1);
    ssel = 1'b0;
    repeat (6) @(negedge clk);
    dn_pulse();
    dn_pulse();
    #2 reset_n = 1'b0;
    #1;
    check("arst_word", spi_data_to_send, 0);
    check("arst_rdreq", fifo_rdreq, 0);
    check("arst_active", frame_active, 0);
    check("arst_state", dbg_state, 0);
    ssel = 1'b1;
    data_needed = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int m = 0; m < NUM_MICS; m++) begin
      wr_cnt[m] = rd_cnt[m];
      ref_q[m].delete();
    end
    m_frame_cnt = 8'd0;
    m_urun_prev = 8'd0;
    repeat (4) @(negedge clk);
    fill_all(5);
    run_frame(LEN, 1'b0, 1'b0);

    check("rdreq_one_hot", multi_hot, 0);
    check("rdreq_on_empty", rd_on_empty, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no end expected end");
    $fatal(1, "watchdog");
  end

endmodule
